// File: rtl/div_pkg.sv
// Shared constants and state encoding for the restoring divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 8;
    localparam int unsigned DIV_ITERS = 8;
    localparam int unsigned CNT_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/cla_subtractor9.sv
// 9-bit carry-lookahead subtractor: diff = a - b computed as a + ~b + 1.
module cla_subtractor9 (
    input  logic [8:0] a,
    input  logic [8:0] b,
    output logic [8:0] diff,
    output logic       no_borrow
);

    logic [8:0] gen;
    logic [8:0] prop;
    logic [9:0] carry;
    logic       chain;

    // Each carry is a flat sum of generate terms gated by the propagates above them.
    always_comb begin
        gen   = a & ~b;
        prop  = a ^ ~b;
        carry = '0;
        chain = 1'b0;
        carry[0] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            carry[i+1] = gen[i];
            chain      = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                carry[i+1] = carry[i+1] | (chain & gen[j]);
                chain      = chain & prop[j];
            end
            carry[i+1] = carry[i+1] | (chain & carry[0]);
        end
        diff      = prop ^ carry[8:0];
        no_borrow = carry[9];
    end

endmodule

// File: rtl/restoring_divider8.sv
// Unsigned restoring divider: one quotient bit per cycle, registered results.
module restoring_divider8
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Done,
    output logic             DivByZero
);

    div_state_t           state, state_n;
    logic [WIDTH-1:0]     q_reg, q_n;
    logic [WIDTH-1:0]     d_reg, d_n;
    logic [WIDTH-1:0]     r_reg, r_n;
    logic [CNT_WIDTH-1:0] cnt, cnt_n;
    logic                 iters_done, iters_done_n;
    logic [WIDTH-1:0]     quo_n, rem_n;
    logic                 done_n, dbz_n;

    logic [WIDTH:0]       shifted;
    logic [WIDTH:0]       diff;
    logic                 no_borrow;
    logic                 unused_diff_msb;

    assign shifted         = {r_reg, q_reg[WIDTH-1]};
    // A successful trial subtraction is always below the divisor, so its top bit is zero.
    assign unused_diff_msb = diff[WIDTH];

    cla_subtractor9 u_sub (
        .a         (shifted),
        .b         ({1'b0, d_reg}),
        .diff      (diff),
        .no_borrow (no_borrow)
    );

    always_comb begin
        state_n      = state;
        q_n          = q_reg;
        d_n          = d_reg;
        r_n          = r_reg;
        cnt_n        = cnt;
        iters_done_n = iters_done;
        quo_n        = Quotient;
        rem_n        = Remainder;
        done_n       = Done;
        dbz_n        = DivByZero;
        case (state)
            IDLE: begin
                if (Run) begin
                    q_n          = Dividend;
                    d_n          = Divisor;
                    r_n          = '0;
                    cnt_n        = '0;
                    iters_done_n = 1'b0;
                    done_n       = 1'b0;
                    dbz_n        = 1'b0;
                    if (Divisor == '0) begin
                        state_n = DONE;
                        quo_n   = '1;
                        rem_n   = Dividend;
                        done_n  = 1'b1;
                        dbz_n   = 1'b1;
                    end else begin
                        state_n = CALC;
                    end
                end
            end
            CALC: begin
                // The cycle after the last iteration publishes the result.
                if (iters_done) begin
                    state_n = DONE;
                    quo_n   = q_reg;
                    rem_n   = r_reg;
                    done_n  = 1'b1;
                end else begin
                    r_n   = no_borrow ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    q_n   = {q_reg[WIDTH-2:0], no_borrow};
                    cnt_n = cnt + CNT_WIDTH'(1);
                    if (cnt == CNT_WIDTH'(DIV_ITERS - 1)) begin
                        iters_done_n = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!Run) begin
                    state_n = IDLE;
                    done_n  = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            q_reg      <= '0;
            d_reg      <= '0;
            r_reg      <= '0;
            cnt        <= '0;
            iters_done <= 1'b0;
            Quotient   <= '0;
            Remainder  <= '0;
            Done       <= 1'b0;
            DivByZero  <= 1'b0;
        end else begin
            state      <= state_n;
            q_reg      <= q_n;
            d_reg      <= d_n;
            r_reg      <= r_n;
            cnt        <= cnt_n;
            iters_done <= iters_done_n;
            Quotient   <= quo_n;
            Remainder  <= rem_n;
            Done       <= done_n;
            DivByZero  <= dbz_n;
        end
    end

endmodule

// File: tb/tb_restoring_divider8.sv
// Directed-vector bench for restoring_divider8 with reset, run-hold and sweep sequences.
module tb_restoring_divider8;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Run;
    logic [7:0] Dividend;
    logic [7:0] Divisor;
    logic [7:0] Quotient;
    logic [7:0] Remainder;
    logic       Done;
    logic       DivByZero;

    int checks   = 0;
    int failures = 0;

    restoring_divider8 #(.WIDTH(8)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Run       (Run),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Done      (Done),
        .DivByZero (DivByZero)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        int         lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Pulse Run for one edge, scramble operands, wait for Done, then let Run=0 return to IDLE.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                           output logic [7:0] q, output logic [7:0] r, output logic dbz,
                           output int lat, output logic done_after, output logic [7:0] q_after);
        Dividend = a;
        Divisor  = b;
        Run      = 1'b1;
        @(posedge Clk); #1;
        Run      = 1'b0;
        Dividend = 8'hA5;
        Divisor  = 8'h3C;
        lat = 0;
        while (!Done && lat < 20) begin
            @(posedge Clk); #1;
            lat++;
        end
        q   = Quotient;
        r   = Remainder;
        dbz = DivByZero;
        @(posedge Clk); #1;
        done_after = Done;
        q_after    = Quotient;
    endtask

    initial begin
        vec_t       vecs [10];
        logic [7:0] q, r, q_after;
        logic       dbz, done_after, prev_done;
        int         lat, rises;

        // Latency counts edges after the start edge; divide-by-zero finishes on the start edge itself.
        vecs[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 9};
        vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 9};
        vecs[2] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 9};
        vecs[3] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 9};
        vecs[4] = '{8'd100, 8'd0,   8'hFF,  8'd100, 1'b1, 0};
        vecs[5] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 9};
        vecs[6] = '{8'd128, 8'd16,  8'd8,   8'd0,   1'b0, 9};
        vecs[7] = '{8'd1,   8'd255, 8'd0,   8'd1,   1'b0, 9};
        vecs[8] = '{8'd254, 8'd3,   8'd84,  8'd2,   1'b0, 9};
        vecs[9] = '{8'd17,  8'd4,   8'd4,   8'd1,   1'b0, 9};

        Reset    = 1'b1;
        Run      = 1'b1;
        Dividend = 8'd200;
        Divisor  = 8'd7;
        repeat (3) @(posedge Clk);
        #1;
        check("reset_quotient",  32'(Quotient),  32'd0);
        check("reset_remainder", 32'(Remainder), 32'd0);
        check("reset_done",      32'(Done),      32'd0);
        check("reset_dbz",       32'(DivByZero), 32'd0);
        Run   = 1'b0;
        Reset = 1'b0;
        @(posedge Clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_div(vecs[i].a, vecs[i].b, q, r, dbz, lat, done_after, q_after);
            check($sformatf("vec%0d_quotient", i),  32'(q),          32'(vecs[i].q));
            check($sformatf("vec%0d_remainder", i), 32'(r),          32'(vecs[i].r));
            check($sformatf("vec%0d_dbz", i),       32'(dbz),        32'(vecs[i].dbz));
            check($sformatf("vec%0d_latency", i),   32'(lat),        32'(vecs[i].lat));
            check($sformatf("vec%0d_done_drop", i), 32'(done_after), 32'd0);
            check($sformatf("vec%0d_retained", i),  32'(q_after),    32'(vecs[i].q));
        end

        // Reset in the middle of a calculation, after a divide-by-zero left nonzero outputs.
        run_div(8'd100, 8'd0, q, r, dbz, lat, done_after, q_after);
        Dividend = 8'd200;
        Divisor  = 8'd7;
        Run      = 1'b1;
        @(posedge Clk); #1;
        Run = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("calc_hold_quotient",  32'(Quotient),  32'd255);
        check("calc_hold_remainder", 32'(Remainder), 32'd100);
        check("calc_dbz_cleared",    32'(DivByZero), 32'd0);
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        check("midreset_quotient",  32'(Quotient),  32'd0);
        check("midreset_remainder", 32'(Remainder), 32'd0);
        check("midreset_done",      32'(Done),      32'd0);
        check("midreset_dbz",       32'(DivByZero), 32'd0);
        repeat (12) @(posedge Clk);
        #1;
        check("midreset_stays_idle", 32'(Done), 32'd0);
        run_div(8'd200, 8'd7, q, r, dbz, lat, done_after, q_after);
        check("restart_quotient",  32'(q),   32'd28);
        check("restart_remainder", 32'(r),   32'd4);
        check("restart_latency",   32'(lat), 32'd9);

        // Run held high: exactly one division, then a fresh start after one low cycle.
        Dividend  = 8'd200;
        Divisor   = 8'd7;
        Run       = 1'b1;
        rises     = 0;
        prev_done = Done;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk); #1;
            if (i == 2) begin
                Dividend = 8'd50;
                Divisor  = 8'd3;
            end
            if (Done && !prev_done) rises++;
            prev_done = Done;
        end
        check("hold_single_division", 32'(rises),     32'd1);
        check("hold_done_high",       32'(Done),      32'd1);
        check("hold_quotient",        32'(Quotient),  32'd28);
        check("hold_remainder",       32'(Remainder), 32'd4);
        Run = 1'b0;
        @(posedge Clk); #1;
        check("hold_done_drop", 32'(Done), 32'd0);
        Run      = 1'b1;
        Dividend = 8'd9;
        Divisor  = 8'd2;
        @(posedge Clk); #1;
        lat = 0;
        while (!Done && lat < 20) begin
            @(posedge Clk); #1;
            lat++;
        end
        check("rerun_latency",   32'(lat),       32'd9);
        check("rerun_quotient",  32'(Quotient),  32'd4);
        check("rerun_remainder", 32'(Remainder), 32'd1);
        Run = 1'b0;
        @(posedge Clk); #1;

        // Strided dividends against every nonzero divisor.
        for (int a = 0; a < 256; a += 17) begin
            for (int b = 1; b < 256; b++) begin
                run_div(8'(a), 8'(b), q, r, dbz, lat, done_after, q_after);
                check($sformatf("sweep_%0d_div_%0d", a, b),
                      {7'd0, dbz, 4'(lat), 4'd0, q, r},
                      {7'd0, 1'b0, 4'd9, 4'd0, 8'(a / b), 8'(a % b)});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
